// File: rtl/op_buf_pkg.sv
// Shared constants and types for the memory-mapped output buffer.
package op_buf_pkg;

  localparam logic [5:0] LEDR_OFF   = 6'h00;
  localparam logic [5:0] LEDG_OFF   = 6'h10;
  localparam logic [5:0] HEX_LO_OFF = 6'h20;
  localparam logic [5:0] HEX_HI_OFF = 6'h24;
  localparam logic [5:0] LCD_OFF    = 6'h30;

  localparam int WINDOW_BYTES = 64;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  function automatic logic [3:0] word_idx(input logic [5:0] off);
    return off[5:2];
  endfunction

endpackage

// File: rtl/op_buf_byte_en.sv
// Store lane decode: byte enables, lane-replicated write data and misalign flag.
module op_buf_byte_en
  import op_buf_pkg::*;
(
  input  logic        req,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    byte_en  = 4'b0000;
    misalign = 1'b0;
    wdata    = st_data;
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        wdata = {2{st_data[15:0]}};
        if (addr_lo[0]) misalign = 1'b1;
        else            byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        if (addr_lo != 2'b00) misalign = 1'b1;
        else                  byte_en  = 4'b1111;
      end
      default: ;
    endcase
    // Nothing is flagged or written unless this block is actually targeted.
    if (!req) begin
      byte_en  = 4'b0000;
      misalign = 1'b0;
    end
  end

endmodule

// File: rtl/output_buffer.sv
// Output peripheral register window: LEDs, 7-segment digits and LCD,
// with combinational read-back for the single-cycle LSU.
module output_buffer
  import op_buf_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h7000,
  parameter logic [5:0]  LCD_OFFSET = LCD_OFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en_op_buf,
  input  logic [15:0] i_lsu_addr,
  input  logic        i_lsu_wren,
  input  logic [1:0]  i_lsu_size,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd,
  output logic        o_lcd_strobe
);

  logic [5:0]  off;
  logic [3:0]  word;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ledr, ledg, hex_lo, hex_hi, lcd;
  logic        lcd_strobe;

  // BASE_ADDR is 64-byte aligned, so the offset is just the low address bits.
  assign off  = 6'(i_lsu_addr - BASE_ADDR);
  assign word = word_idx(off);

  op_buf_byte_en u_byte_en (
    .req      (i_en_op_buf & i_lsu_wren),
    .size     (i_lsu_size),
    .addr_lo  (off[1:0]),
    .st_data  (i_st_data),
    .byte_en  (be),
    .wdata    (wdata),
    .misalign (o_misalign)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr       <= '0;
      ledg       <= '0;
      hex_lo     <= '0;
      hex_hi     <= '0;
      lcd        <= '0;
      lcd_strobe <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (word == word_idx(LEDR_OFF))   ledr[8*b +: 8]   <= wdata[8*b +: 8];
          if (word == word_idx(LEDG_OFF))   ledg[8*b +: 8]   <= wdata[8*b +: 8];
          if (word == word_idx(HEX_LO_OFF)) hex_lo[8*b +: 8] <= wdata[8*b +: 8];
          if (word == word_idx(HEX_HI_OFF)) hex_hi[8*b +: 8] <= wdata[8*b +: 8];
          if (word == word_idx(LCD_OFFSET)) lcd[8*b +: 8]    <= wdata[8*b +: 8];
        end
      end
      lcd_strobe <= (word == word_idx(LCD_OFFSET)) && (be != 4'b0000);
    end
  end

  always_comb begin
    o_ld_data = '0;
    if (i_en_op_buf) begin
      if      (word == word_idx(LEDR_OFF))   o_ld_data = ledr;
      else if (word == word_idx(LEDG_OFF))   o_ld_data = ledg;
      else if (word == word_idx(HEX_LO_OFF)) o_ld_data = hex_lo;
      else if (word == word_idx(HEX_HI_OFF)) o_ld_data = hex_hi;
      else if (word == word_idx(LCD_OFFSET)) o_ld_data = lcd;
    end
  end

  assign o_io_ledr    = ledr;
  assign o_io_ledg    = ledg;
  assign o_io_lcd     = lcd;
  assign o_lcd_strobe = lcd_strobe;
  assign o_io_hex0    = hex_lo[6:0];
  assign o_io_hex1    = hex_lo[14:8];
  assign o_io_hex2    = hex_lo[22:16];
  assign o_io_hex3    = hex_lo[30:24];
  assign o_io_hex4    = hex_hi[6:0];
  assign o_io_hex5    = hex_hi[14:8];
  assign o_io_hex6    = hex_hi[22:16];
  assign o_io_hex7    = hex_hi[30:24];

endmodule
